// File: rtl/ir_assembler.sv
// ir_assembler: collects BEATS consecutive DATA_W-wide bus beats into a shadow
// register and commits the finished word atomically to opc_iraddr.
//
// Optional feature: define IR_PARITY_EN to add per-beat even-parity checking
// (data_par input, par_err output).
//
// Ports:
//   clk1       - clock, rising edge
//   rst        - asynchronous active-low reset
//   ena        - beat strobe; data is a valid beat while high
//   data       - bus beat (DATA_W)
//   flush      - synchronous abort of a partial assembly (wins over ena)
//   data_par   - even parity of data (IR_PARITY_EN only)
//   par_err    - parity error of the last committed word (IR_PARITY_EN only)
//   opc_iraddr - committed instruction word (IR_W)
//   opcode     - top OPC_W bits of opc_iraddr (combinational slice)
//   ir_addr    - remaining low bits of opc_iraddr (combinational slice)
//   ir_valid   - one-cycle pulse when a new word was committed
//   beat_cnt   - index of the next beat expected
module ir_assembler #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned OPC_W     = 3,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IR_W     = DATA_W * BEATS,
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [DATA_W-1:0]     data,
  input  logic                  flush,
`ifdef IR_PARITY_EN
  input  logic                  data_par,
  output logic                  par_err,
`endif
  output logic [IR_W-1:0]       opc_iraddr,
  output logic [OPC_W-1:0]      opcode,
  output logic [IR_W-OPC_W-1:0] ir_addr,
  output logic                  ir_valid,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  logic [IR_W-1:0]  shadow_q, shadow_d;
  logic [IR_W-1:0]  opc_q, opc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] slot_sel;
  logic [IR_W-1:0]  merged;
  logic             last_beat;

  // Shadow with the current beat dropped into the slot selected by beat order
  always_comb begin
    slot_sel = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
    merged   = shadow_q;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (slot_sel == CNT_W'(k)) merged[k*DATA_W +: DATA_W] = data;
    end
    last_beat = (cnt_q == LAST_IDX);
  end

  // Next-state: flush > accepted beat > idle (ena low abandons the sequence)
  always_comb begin
    shadow_d = shadow_q;
    opc_d    = opc_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    if (flush) begin
      cnt_d    = '0;
      shadow_d = '0;
    end else if (ena) begin
      shadow_d = merged;
      if (last_beat) begin
        opc_d   = merged;
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      opc_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      opc_q    <= opc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

`ifdef IR_PARITY_EN
  logic sticky_q, sticky_d;
  logic par_err_q, par_err_d;
  logic beat_err;

  // Sticky error accumulates over the assembly and is folded into par_err on commit
  always_comb begin
    beat_err  = (^data) ^ data_par;
    sticky_d  = sticky_q;
    par_err_d = par_err_q;
    if (flush) begin
      sticky_d = 1'b0;
    end else if (ena) begin
      if (last_beat) begin
        par_err_d = sticky_q | beat_err;
        sticky_d  = 1'b0;
      end else begin
        sticky_d = sticky_q | beat_err;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      sticky_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      sticky_q  <= sticky_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign opc_iraddr = opc_q;
  assign ir_valid   = valid_q;
  assign beat_cnt   = cnt_q;
  assign opcode     = opc_q[IR_W-1 -: OPC_W];
  assign ir_addr    = opc_q[IR_W-OPC_W-1:0];

endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: default instance (8x2, MSB first), an
// LSB-first instance and a 4-beat instance share data/flush/rst, each has
// its own ena.
module tb_ir_assembler;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        ena_a, ena_l, ena_4;
  logic [7:0]  data;
  logic        flush;
  logic        data_par;
  logic        par_flip;

  logic [15:0] opc_a, opc_l;
  logic [31:0] opc_4;
  logic [2:0]  opcode_a, opcode_l, opcode_4;
  logic [12:0] addr_a, addr_l;
  logic [28:0] addr_4;
  logic        valid_a, valid_l, valid_4;
  logic        cnt_a, cnt_l;
  logic [1:0]  cnt_4;
  logic        perr_a, perr_l, perr_4;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  ir_assembler u_dut (
    .clk1(clk1), .rst(rst), .ena(ena_a), .data(data), .flush(flush),
`ifdef IR_PARITY_EN
    .data_par(data_par), .par_err(perr_a),
`endif
    .opc_iraddr(opc_a), .opcode(opcode_a), .ir_addr(addr_a),
    .ir_valid(valid_a), .beat_cnt(cnt_a)
  );

  ir_assembler #(.MSB_FIRST(1'b0)) u_lsb (
    .clk1(clk1), .rst(rst), .ena(ena_l), .data(data), .flush(flush),
`ifdef IR_PARITY_EN
    .data_par(data_par), .par_err(perr_l),
`endif
    .opc_iraddr(opc_l), .opcode(opcode_l), .ir_addr(addr_l),
    .ir_valid(valid_l), .beat_cnt(cnt_l)
  );

  ir_assembler #(.BEATS(4)) u_b4 (
    .clk1(clk1), .rst(rst), .ena(ena_4), .data(data), .flush(flush),
`ifdef IR_PARITY_EN
    .data_par(data_par), .par_err(perr_4),
`endif
    .opc_iraddr(opc_4), .opcode(opcode_4), .ir_addr(addr_4),
    .ir_valid(valid_4), .beat_cnt(cnt_4)
  );

  // Drive one cycle of stimulus, then settle 1 time unit past the edge
  task automatic cyc(input logic ea, input logic el, input logic e4,
                     input logic [7:0] d, input logic f);
    ena_a    = ea;
    ena_l    = el;
    ena_4    = e4;
    data     = d;
    flush    = f;
    data_par = (^d) ^ par_flip;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h00, 0);
    rst = 1'b1;
    total++;
    if (opc_a !== 16'h0000 || cnt_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_init opc=%h cnt=%b valid=%b want 0000/0/0", opc_a, cnt_a, valid_a);
    end
    cyc(1, 0, 0, 8'h11, 0);
    cyc(1, 0, 0, 8'h11, 0);
    total++;
    if (opc_a !== 16'h1111) begin
      bad++;
      $display("FAIL pre_reset_commit opc=%h want 1111", opc_a);
    end
    cyc(1, 0, 0, 8'h22, 0);
    // assert reset mid-sequence and hold it 3 cycles with beats still arriving
    rst = 1'b0;
    cyc(1, 0, 0, 8'h33, 0);
    cyc(1, 0, 0, 8'h33, 0);
    cyc(1, 0, 0, 8'h33, 0);
    total++;
    if (opc_a !== 16'h0000 || cnt_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold opc=%h cnt=%b valid=%b want 0000/0/0", opc_a, cnt_a, valid_a);
    end
    rst = 1'b1;
    cyc(1, 0, 0, 8'hA5, 0);
    total++;
    if (valid_a !== 1'b0 || cnt_a !== 1'b1 || opc_a !== 16'h0000) begin
      bad++;
      $display("FAIL first_beat valid=%b cnt=%b opc=%h want 0/1/0000", valid_a, cnt_a, opc_a);
    end
    cyc(1, 0, 0, 8'h3C, 0);
    total++;
    if (opc_a !== 16'hA53C || opcode_a !== 3'b101 || addr_a !== 13'h053C || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL commit_a53c opc=%h opcode=%b addr=%h valid=%b want a53c/101/053c/1",
               opc_a, opcode_a, addr_a, valid_a);
    end
    cyc(0, 0, 0, 8'h00, 0);
    total++;
    if (valid_a !== 1'b0 || opc_a !== 16'hA53C) begin
      bad++;
      $display("FAIL valid_pulse valid=%b opc=%h want 0/a53c", valid_a, opc_a);
    end
  endtask

  task automatic test_beat_order;
    cyc(0, 1, 0, 8'hA5, 0);
    cyc(0, 1, 0, 8'h3C, 0);
    total++;
    if (opc_l !== 16'h3CA5 || valid_l !== 1'b1) begin
      bad++;
      $display("FAIL lsb_first opc=%h valid=%b want 3ca5/1", opc_l, valid_l);
    end
    cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h22, 0);
    cyc(0, 0, 1, 8'h33, 0);
    total++;
    if (cnt_4 !== 2'd3 || opc_4 !== 32'h0000_0000 || valid_4 !== 1'b0) begin
      bad++;
      $display("FAIL b4_partial cnt=%0d opc=%h valid=%b want 3/00000000/0", cnt_4, opc_4, valid_4);
    end
    cyc(0, 0, 1, 8'h44, 0);
    total++;
    if (opc_4 !== 32'h1122_3344 || valid_4 !== 1'b1 || cnt_4 !== 2'd0) begin
      bad++;
      $display("FAIL b4_commit opc=%h valid=%b cnt=%0d want 11223344/1/0", opc_4, valid_4, cnt_4);
    end
    cyc(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_abort;
    cyc(1, 0, 0, 8'h12, 0);
    cyc(1, 0, 0, 8'h34, 0);
    cyc(1, 0, 0, 8'hFF, 0);
    total++;
    if (cnt_a !== 1'b1 || opc_a !== 16'h1234) begin
      bad++;
      $display("FAIL abort_partial cnt=%b opc=%h want 1/1234", cnt_a, opc_a);
    end
    cyc(0, 0, 0, 8'h00, 0);
    total++;
    if (cnt_a !== 1'b0 || opc_a !== 16'h1234 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold cnt=%b opc=%h valid=%b want 0/1234/0", cnt_a, opc_a, valid_a);
    end
    cyc(1, 0, 0, 8'h56, 0);
    cyc(1, 0, 0, 8'h78, 0);
    total++;
    if (opc_a !== 16'h5678 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL abort_resume opc=%h valid=%b want 5678/1", opc_a, valid_a);
    end
  endtask

  task automatic test_flush;
    cyc(1, 0, 1, 8'h9A, 0);
    cyc(1, 0, 1, 8'hBC, 1);
    total++;
    if (cnt_a !== 1'b0 || opc_a !== 16'h5678 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL flush_prio cnt=%b opc=%h valid=%b want 0/5678/0", cnt_a, opc_a, valid_a);
    end
    total++;
    if (cnt_4 !== 2'd0 || opc_4 !== 32'h1122_3344) begin
      bad++;
      $display("FAIL flush_b4 cnt=%0d opc=%h want 0/11223344", cnt_4, opc_4);
    end
    cyc(1, 0, 0, 8'hDE, 0);
    cyc(1, 0, 0, 8'hF0, 0);
    total++;
    if (opc_a !== 16'hDEF0 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL flush_resume opc=%h valid=%b want def0/1", opc_a, valid_a);
    end
  endtask

  task automatic test_back_to_back;
    logic        exp_v;
    logic [15:0] exp_w;
    cyc(0, 0, 0, 8'h00, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 0, 8'(i), 0);
      exp_v = ((i % 2) == 0);
      total++;
      if (valid_a !== exp_v) begin
        bad++;
        $display("FAIL stream_valid cycle=%0d valid=%b want %b", i, valid_a, exp_v);
      end
      if (exp_v) begin
        exp_w = {8'(i - 1), 8'(i)};
        total++;
        if (opc_a !== exp_w) begin
          bad++;
          $display("FAIL stream_word cycle=%0d opc=%h want %h", i, opc_a, exp_w);
        end
      end
    end
    cyc(0, 0, 0, 8'h00, 0);
  endtask

`ifdef IR_PARITY_EN
  task automatic test_parity;
    par_flip = 1'b1;
    cyc(1, 0, 0, 8'h03, 0);
    par_flip = 1'b0;
    cyc(1, 0, 0, 8'h00, 0);
    total++;
    if (opc_a !== 16'h0300 || perr_a !== 1'b1 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL parity_err opc=%h par_err=%b valid=%b want 0300/1/1", opc_a, perr_a, valid_a);
    end
    cyc(1, 0, 0, 8'h12, 0);
    total++;
    if (perr_a !== 1'b1) begin
      bad++;
      $display("FAIL parity_hold par_err=%b want 1", perr_a);
    end
    cyc(1, 0, 0, 8'h34, 0);
    total++;
    if (opc_a !== 16'h1234 || perr_a !== 1'b0) begin
      bad++;
      $display("FAIL parity_clean opc=%h par_err=%b want 1234/0", opc_a, perr_a);
    end
    cyc(0, 0, 0, 8'h00, 0);
  endtask
`endif

  initial begin
    rst      = 1'b0;
    ena_a    = 1'b0;
    ena_l    = 1'b0;
    ena_4    = 1'b0;
    data     = 8'h00;
    flush    = 1'b0;
    par_flip = 1'b0;
    data_par = 1'b0;
    test_reset();
    test_beat_order();
    test_abort();
    test_flush();
    test_back_to_back();
`ifdef IR_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
